// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared constants and types for the instruction fetch controller.
//   ROM_SIZE_DEF    : default instruction-memory depth (words)
//   INSTR_WIDTH_DEF : default instruction word width (bits)
//   HALT_OPCODE     : instruction word that ends program execution
//   fetch_state_e   : fetch FSM state encoding (IDLE / RUN / HALTED)
package fetch_pkg;

  localparam int ROM_SIZE_DEF    = 256;
  localparam int INSTR_WIDTH_DEF = 9;

  localparam logic [8:0] HALT_OPCODE = 9'b111000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_pc_next.sv
// pc_next -- next program-counter selection for the fetch controller.
// Ports:
//   pc            in  : current PC
//   branch_taken  in  : select branch_target instead of the sequential PC
//   branch_target in  : absolute branch destination
//   pc_nxt        out : PC for the next fetch (sequential step wraps to 0
//                       after the last ROM word)
module pc_next
  import fetch_pkg::*;
#(
  parameter  int ROM_SIZE = ROM_SIZE_DEF,
  localparam int AW       = $clog2(ROM_SIZE)
) (
  input  logic [AW-1:0] pc,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic [AW-1:0] pc_nxt
);

  // Explicit compare so non-power-of-two ROM sizes also wrap correctly.
  localparam logic [AW-1:0] PC_LAST = AW'(ROM_SIZE - 1);

  always_comb begin
    pc_nxt = pc + AW'(1);
    if (pc == PC_LAST) pc_nxt = '0;
    if (branch_taken)  pc_nxt = branch_target;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch sequencer: walks the PC through the
// instruction ROM, registers each fetched word for decode and stops on HALT.
// Optional feature: define FETCH_CTRL_CYCLE_CNT_EN to add a 16-bit saturating
// count of RUN cycles (cycle_count).
// Ports:
//   clk           in  : clock, rising edge
//   reset         in  : asynchronous active-high reset
//   start         in  : begin/restart at address 0 (ignored while running)
//   stall         in  : freeze PC and instruction register this cycle
//   branch_taken  in  : take branch_target instead of PC+1
//   branch_target in  : absolute branch destination
//   instr_in      in  : ROM word at instr_addr
//   instr_addr    out : current PC
//   instr_out     out : registered instruction
//   instr_valid   out : instr_out was fetched on the last edge
//   done          out : HALT fetched, program finished
//   cycle_count   out : RUN cycles since the last start (optional)
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | after reset, waiting for start
// RUN    | fetching one word per unstalled cycle
// HALTED | HALT fetched; done high, waiting for start to rerun
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter  int ROM_SIZE    = ROM_SIZE_DEF,
  parameter  int INSTR_WIDTH = INSTR_WIDTH_DEF,
  localparam int AW          = $clog2(ROM_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [AW-1:0]          branch_target,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [AW-1:0]          instr_addr,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  output logic                   done
`ifdef FETCH_CTRL_CYCLE_CNT_EN
  ,output logic [15:0]           cycle_count
`endif
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_RUN    = RUN;
  localparam logic [1:0] S_HALTED = HALTED;

  localparam logic [INSTR_WIDTH-1:0] HALT_WORD = INSTR_WIDTH'(HALT_OPCODE);

  logic [1:0]    state;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_nxt;
  logic          halt_fetch;
  logic          start_accept;

  assign halt_fetch   = (instr_in == HALT_WORD);
  // start only matters outside RUN; a running program cannot be restarted.
  assign start_accept = start && (state != S_RUN);

  pc_next #(
    .ROM_SIZE(ROM_SIZE)
  ) u_pc_next (
    .pc           (pc),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc_nxt       (pc_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        S_IDLE, S_HALTED: begin
          if (start_accept) begin
            state <= S_RUN;
            pc    <= '0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            instr_out   <= instr_in;
            instr_valid <= 1'b1;
            // HALT beats a branch: PC stays on the HALT word.
            if (halt_fetch) state <= S_HALTED;
            else            pc    <= pc_nxt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign instr_addr = pc;
  assign done       = (state == S_HALTED);

`ifdef FETCH_CTRL_CYCLE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (start_accept) begin
      cycle_count <= '0;
    end else if (state == S_RUN && cycle_count != 16'hFFFF) begin
      cycle_count <= cycle_count + 16'd1;
    end
  end
`else
  // Default build: no cycle counter.
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int RS = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_target = 8'd0;
  logic [8:0] instr_in;
  logic [7:0] instr_addr;
  logic [8:0] instr_out;
  logic       instr_valid;
  logic       done;
`ifdef FETCH_CTRL_CYCLE_CNT_EN
  logic [15:0] cycle_count;
`endif

  logic [8:0] rom [RS];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign instr_in = rom[instr_addr];

  fetch_ctrl #(.ROM_SIZE(RS), .INSTR_WIDTH(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr_in     (instr_in),
    .instr_addr   (instr_addr),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .done         (done)
`ifdef FETCH_CTRL_CYCLE_CNT_EN
    ,.cycle_count (cycle_count)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: "running" means fetching, "finished" means HALT seen.
  int m_pc = 0;
  int m_out = 0;
  bit m_valid = 0;
  bit m_running = 0;
  bit m_finished = 0;
`ifdef FETCH_CTRL_CYCLE_CNT_EN
  int m_cnt = 0;
`endif

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 0; m_out = 0; m_valid = 0; m_running = 0; m_finished = 0;
`ifdef FETCH_CTRL_CYCLE_CNT_EN
      m_cnt = 0;
`endif
    end else if (!m_running) begin
      m_valid = 0;
      if (start) begin
        m_pc = 0; m_running = 1; m_finished = 0;
`ifdef FETCH_CTRL_CYCLE_CNT_EN
        m_cnt = 0;
`endif
      end
    end else begin
`ifdef FETCH_CTRL_CYCLE_CNT_EN
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
      if (stall) begin
        m_valid = 0;
      end else begin
        m_out   = int'(rom[m_pc]);
        m_valid = 1;
        if (rom[m_pc] == HALT_OPCODE) begin
          m_running = 0; m_finished = 1;
        end else if (branch_taken) begin
          m_pc = int'(branch_target);
        end else begin
          m_pc = (m_pc + 1) % RS;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("model_addr",  32'(instr_addr),  32'(m_pc));
      check("model_out",   32'(instr_out),   32'(m_out));
      check("model_valid", 32'(instr_valid), 32'(m_valid));
      check("model_done",  32'(done),        32'(m_finished));
`ifdef FETCH_CTRL_CYCLE_CNT_EN
      check("model_count", 32'(cycle_count), 32'(m_cnt));
`endif
    end
  end

  task automatic tick(input logic s, input logic sl, input logic b, input logic [7:0] t);
    start = s; stall = sl; branch_taken = b; branch_target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < RS; i++) rom[i] = 9'(i);
    rom[8] = HALT_OPCODE;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr",  32'(instr_addr),  32'd0);
    check("rst_out",   32'(instr_out),   32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_done",  32'(done),        32'd0);
    reset = 1'b0;

    // Idle ignores everything but start
    tick(0, 0, 1, 8'd77);
    check("idle_addr",  32'(instr_addr),  32'd0);
    check("idle_valid", 32'(instr_valid), 32'd0);

    // Straight-line program 0..7 then HALT at 8
    tick(1, 0, 0, 8'd0);
    check("start_addr",  32'(instr_addr),  32'd0);
    check("start_valid", 32'(instr_valid), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick(0, 0, 0, 8'd0);
      check("seq_addr",  32'(instr_addr),  32'(k));
      check("seq_out",   32'(instr_out),   32'(k - 1));
      check("seq_valid", 32'(instr_valid), 32'd1);
    end
    tick(0, 0, 0, 8'd0);
    check("halt_out",   32'(instr_out),   32'h1C0);
    check("halt_valid", 32'(instr_valid), 32'd1);
    check("halt_done",  32'(done),        32'd1);
    check("halt_addr",  32'(instr_addr),  32'd8);
    tick(0, 0, 0, 8'd0);
    check("halted_addr",  32'(instr_addr),  32'd8);
    check("halted_valid", 32'(instr_valid), 32'd0);
    check("halted_done",  32'(done),        32'd1);
    rom[8] = 9'd8;

    // Restart from HALTED, walk to PC=5, then branch to 20 (stalled first)
    tick(1, 0, 0, 8'd0);
    check("restart_addr", 32'(instr_addr), 32'd0);
    check("restart_done", 32'(done),       32'd0);
    for (int k = 0; k < 5; k++) tick(0, 0, 0, 8'd0);
    check("pc5_addr", 32'(instr_addr), 32'd5);
    tick(0, 1, 1, 8'd20);
    check("stall_br_addr",  32'(instr_addr),  32'd5);
    check("stall_br_valid", 32'(instr_valid), 32'd0);
    tick(0, 0, 1, 8'd20);
    check("br_addr", 32'(instr_addr), 32'd20);
    check("br_out",  32'(instr_out),  32'd5);
    tick(1, 0, 0, 8'd0);
    check("run_start_ignored", 32'(instr_addr), 32'd21);

    // Three-cycle stall at PC=10
    tick(0, 0, 1, 8'd10);
    check("br10_addr", 32'(instr_addr), 32'd10);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0, 8'd0);
      check("stall3_addr",  32'(instr_addr),  32'd10);
      check("stall3_valid", 32'(instr_valid), 32'd0);
    end
    tick(0, 0, 0, 8'd0);
    check("resume_addr",  32'(instr_addr),  32'd11);
    check("resume_out",   32'(instr_out),   32'd10);
    check("resume_valid", 32'(instr_valid), 32'd1);

    // Wrap from 255
    tick(0, 0, 1, 8'd255);
    check("br255_addr", 32'(instr_addr), 32'd255);
    tick(0, 0, 0, 8'd0);
    check("wrap_addr", 32'(instr_addr), 32'd0);
    check("wrap_out",  32'(instr_out),  32'd255);

    // HALT beats a simultaneous branch
    rom[30] = HALT_OPCODE;
    tick(0, 0, 1, 8'd30);
    check("br30_addr", 32'(instr_addr), 32'd30);
    tick(0, 0, 1, 8'd50);
    check("haltpri_addr", 32'(instr_addr), 32'd30);
    check("haltpri_done", 32'(done),       32'd1);
    check("haltpri_out",  32'(instr_out),  32'h1C0);
    rom[30] = 9'd30;

    // Mid-run async reset at PC=12
    tick(1, 0, 0, 8'd0);
    tick(0, 0, 1, 8'd12);
    check("br12_addr", 32'(instr_addr), 32'd12);
    tick(0, 0, 0, 8'd0);
    tick(0, 0, 1, 8'd12);
    #2;
    reset = 1'b1;
    #1;
    check("async_addr",  32'(instr_addr),  32'd0);
    check("async_out",   32'(instr_out),   32'd0);
    check("async_valid", 32'(instr_valid), 32'd0);
    check("async_done",  32'(done),        32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(0, 0, 0, 8'd0);
    check("post_rst_idle", 32'(instr_valid), 32'd0);
    tick(1, 0, 0, 8'd0);
    check("post_rst_start", 32'(instr_addr), 32'd0);
    tick(0, 0, 0, 8'd0);
    check("post_rst_addr", 32'(instr_addr), 32'd1);
    check("post_rst_out",  32'(instr_out),  32'd0);

    // 8 RUN cycles with 2 stalls, HALT at 5
    rom[5] = HALT_OPCODE;
    tick(0, 1, 0, 8'd0);
    tick(0, 0, 1, 8'd40);
    tick(0, 0, 0, 8'd0);
    tick(0, 0, 0, 8'd0);
    tick(0, 0, 0, 8'd0);
    check("cnt_pre_halt_done", 32'(done), 32'd0);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick(1, 0, 0, 8'd0);
`ifdef FETCH_CTRL_CYCLE_CNT_EN
    check("cnt_start", 32'(cycle_count), 32'd0);
`endif
    tick(0, 0, 0, 8'd0);
    tick(0, 0, 0, 8'd0);
    tick(0, 1, 0, 8'd0);
    tick(0, 0, 0, 8'd0);
    tick(0, 0, 0, 8'd0);
    tick(0, 1, 0, 8'd0);
    tick(0, 0, 0, 8'd0);
    tick(0, 0, 0, 8'd0);
    check("cnt_halt_done", 32'(done),       32'd1);
    check("cnt_halt_addr", 32'(instr_addr), 32'd5);
`ifdef FETCH_CTRL_CYCLE_CNT_EN
    check("cnt_eight", 32'(cycle_count), 32'd8);
`endif
    tick(0, 0, 0, 8'd0);
    tick(0, 0, 0, 8'd0);
`ifdef FETCH_CTRL_CYCLE_CNT_EN
    check("cnt_hold", 32'(cycle_count), 32'd8);
`endif
    tick(1, 0, 0, 8'd0);
    check("cnt_restart_addr", 32'(instr_addr), 32'd0);
`ifdef FETCH_CTRL_CYCLE_CNT_EN
    check("cnt_clear", 32'(cycle_count), 32'd0);
`endif
    tick(0, 0, 0, 8'd0);
    rom[5] = 9'd5;
    tick(0, 0, 0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
